// File: rtl/aib_axi_bridge_follower_req_engine.sv
`default_nettype none
// ============================================================================
// Module  : aib_axi_bridge_follower_req_engine (+ _fifo helper)
// Brief   : Follower-side AXI-MM request engine. AW/W/AR requests from the
//           AIB MAC RX are buffered in credit-sized FIFOs and replayed on an
//           AXI4 master port. B/R responses are returned through one-entry
//           output registers to the MAC TX. Each consumed FIFO entry emits
//           one registered credit-return pulse.
// Ports   : clk_wr/rst_wr        clock, synchronous active-high reset
//           rx_aw_*/rx_w_*/rx_ar_* requests from MAC RX (no backpressure)
//           *_credit_rtn         one-cycle credit return pulses
//           m_axi_*              AXI4 master port
//           tx_b_*/tx_r_*        responses to MAC TX
//           err_overflow/err_wlast sticky error flags
// Revision: 1.0 - initial release
// ============================================================================

// Synchronous show-ahead FIFO. A push while full is accepted only when a pop
// frees the head entry in the same cycle.
module aib_axi_bridge_follower_req_engine_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             ovf_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q, rptr_q;
  logic             full, do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;
  assign dout_o  = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
  end
endmodule

module aib_axi_bridge_follower_req_engine #(
  parameter int ADDRWIDTH = 32,
  parameter int IDWIDTH   = 4,
  parameter int DATAWIDTH = 128,
  parameter int AW_DEPTH  = 8,
  parameter int AR_DEPTH  = 8,
  parameter int W_DEPTH   = 16
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr,
  input  logic                   rx_aw_valid,
  input  logic [IDWIDTH-1:0]     rx_aw_id,
  input  logic [ADDRWIDTH-1:0]   rx_aw_addr,
  input  logic [7:0]             rx_aw_len,
  input  logic [2:0]             rx_aw_size,
  input  logic [1:0]             rx_aw_burst,
  input  logic                   rx_w_valid,
  input  logic [DATAWIDTH-1:0]   rx_w_data,
  input  logic [DATAWIDTH/8-1:0] rx_w_strb,
  input  logic                   rx_w_last,
  input  logic                   rx_ar_valid,
  input  logic [IDWIDTH-1:0]     rx_ar_id,
  input  logic [ADDRWIDTH-1:0]   rx_ar_addr,
  input  logic [7:0]             rx_ar_len,
  input  logic [2:0]             rx_ar_size,
  input  logic [1:0]             rx_ar_burst,
  output logic                   aw_credit_rtn,
  output logic                   w_credit_rtn,
  output logic                   ar_credit_rtn,
  output logic [IDWIDTH-1:0]     m_axi_awid,
  output logic [ADDRWIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [DATAWIDTH-1:0]   m_axi_wdata,
  output logic [DATAWIDTH/8-1:0] m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [IDWIDTH-1:0]     m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [IDWIDTH-1:0]     m_axi_arid,
  output logic [ADDRWIDTH-1:0]   m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [IDWIDTH-1:0]     m_axi_rid,
  input  logic [DATAWIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  output logic                   tx_b_valid,
  input  logic                   tx_b_ready,
  output logic [IDWIDTH-1:0]     tx_b_id,
  output logic [1:0]             tx_b_resp,
  output logic                   tx_r_valid,
  input  logic                   tx_r_ready,
  output logic [IDWIDTH-1:0]     tx_r_id,
  output logic [DATAWIDTH-1:0]   tx_r_data,
  output logic [1:0]             tx_r_resp,
  output logic                   tx_r_last,
  output logic                   err_overflow,
  output logic                   err_wlast
);
  localparam int STRBW = DATAWIDTH / 8;
  localparam int AXW   = IDWIDTH + ADDRWIDTH + 13;
  localparam int WW    = DATAWIDTH + STRBW + 1;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_DATA = 2'd2} wr_state_t;

  wr_state_t state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic [AXW-1:0] aw_head, ar_head;
  logic [WW-1:0]  w_head;
  logic aw_empty, w_empty, ar_empty;
  logic aw_ovf, w_ovf, ar_ovf;
  logic aw_pop, w_pop, ar_pop;
  logic w_head_last;

  logic aw_credit_q, w_credit_q, ar_credit_q;
  logic err_overflow_q, err_wlast_q;
  logic tx_b_valid_q, tx_r_valid_q;
  logic [IDWIDTH-1:0]   tx_b_id_q, tx_r_id_q;
  logic [1:0]           tx_b_resp_q, tx_r_resp_q;
  logic [DATAWIDTH-1:0] tx_r_data_q;
  logic                 tx_r_last_q;
  logic b_cap, r_cap;

  aib_axi_bridge_follower_req_engine_fifo #(.WIDTH(AXW), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk_wr), .rst(rst_wr), .push_i(rx_aw_valid),
    .din_i({rx_aw_id, rx_aw_addr, rx_aw_len, rx_aw_size, rx_aw_burst}),
    .pop_i(aw_pop), .dout_o(aw_head), .empty_o(aw_empty), .ovf_o(aw_ovf));

  aib_axi_bridge_follower_req_engine_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk_wr), .rst(rst_wr), .push_i(rx_w_valid),
    .din_i({rx_w_data, rx_w_strb, rx_w_last}),
    .pop_i(w_pop), .dout_o(w_head), .empty_o(w_empty), .ovf_o(w_ovf));

  aib_axi_bridge_follower_req_engine_fifo #(.WIDTH(AXW), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk(clk_wr), .rst(rst_wr), .push_i(rx_ar_valid),
    .din_i({rx_ar_id, rx_ar_addr, rx_ar_len, rx_ar_size, rx_ar_burst}),
    .pop_i(ar_pop), .dout_o(ar_head), .empty_o(ar_empty), .ovf_o(ar_ovf));

  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} = aw_head;
  assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} = ar_head;
  assign {m_axi_wdata, m_axi_wstrb, w_head_last} = w_head;

  // Read path: AR FIFO head is presented directly.
  assign m_axi_arvalid = !ar_empty;
  assign ar_pop        = m_axi_arvalid && m_axi_arready;

  // Write FSM: one burst in flight; wlast comes from the beat counter only.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    aw_pop        = 1'b0;
    w_pop         = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (!aw_empty) state_d = WR_ADDR;
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          aw_pop     = 1'b1;
          beat_cnt_d = m_axi_awlen;
          state_d    = WR_DATA;
        end
      end
      WR_DATA: begin
        m_axi_wvalid = !w_empty;
        m_axi_wlast  = (beat_cnt_q == 8'd0);
        if (m_axi_wvalid && m_axi_wready) begin
          w_pop      = 1'b1;
          beat_cnt_d = beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd0) state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Response skid registers: accept a new response whenever the slot is
  // empty or being drained this cycle. Held off entirely during reset.
  assign m_axi_bready = !rst_wr && (!tx_b_valid_q || tx_b_ready);
  assign m_axi_rready = !rst_wr && (!tx_r_valid_q || tx_r_ready);
  assign b_cap        = m_axi_bvalid && m_axi_bready;
  assign r_cap        = m_axi_rvalid && m_axi_rready;

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q        <= WR_IDLE;
      beat_cnt_q     <= 8'd0;
      aw_credit_q    <= 1'b0;
      w_credit_q     <= 1'b0;
      ar_credit_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_wlast_q    <= 1'b0;
      tx_b_valid_q   <= 1'b0;
      tx_r_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      aw_credit_q    <= aw_pop;
      w_credit_q     <= w_pop;
      ar_credit_q    <= ar_pop;
      err_overflow_q <= err_overflow_q || aw_ovf || w_ovf || ar_ovf;
      err_wlast_q    <= err_wlast_q || (w_pop && (w_head_last != (beat_cnt_q == 8'd0)));
      if (b_cap)           tx_b_valid_q <= 1'b1;
      else if (tx_b_ready) tx_b_valid_q <= 1'b0;
      if (r_cap)           tx_r_valid_q <= 1'b1;
      else if (tx_r_ready) tx_r_valid_q <= 1'b0;
    end
  end

  // Response payloads need no reset; they are qualified by the valid bits.
  always_ff @(posedge clk_wr) begin
    if (b_cap) begin
      tx_b_id_q   <= m_axi_bid;
      tx_b_resp_q <= m_axi_bresp;
    end
    if (r_cap) begin
      tx_r_id_q   <= m_axi_rid;
      tx_r_data_q <= m_axi_rdata;
      tx_r_resp_q <= m_axi_rresp;
      tx_r_last_q <= m_axi_rlast;
    end
  end

  assign aw_credit_rtn = aw_credit_q;
  assign w_credit_rtn  = w_credit_q;
  assign ar_credit_rtn = ar_credit_q;
  assign err_overflow  = err_overflow_q;
  assign err_wlast     = err_wlast_q;
  assign tx_b_valid    = tx_b_valid_q;
  assign tx_b_id       = tx_b_id_q;
  assign tx_b_resp     = tx_b_resp_q;
  assign tx_r_valid    = tx_r_valid_q;
  assign tx_r_id       = tx_r_id_q;
  assign tx_r_data     = tx_r_data_q;
  assign tx_r_resp     = tx_r_resp_q;
  assign tx_r_last     = tx_r_last_q;
endmodule
`default_nettype wire

// File: tb/tb_aib_axi_bridge_follower_req_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_aib_axi_bridge_follower_req_engine
// Brief   : Directed bench for the follower request engine. B path is driven
//           from a vector table; write, read, overflow, reset and full-FIFO
//           cases use hand-written sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aib_axi_bridge_follower_req_engine;
  logic clk_wr = 1'b0;
  logic rst_wr;
  logic rx_aw_valid, rx_w_valid, rx_ar_valid, rx_w_last;
  logic [3:0] rx_aw_id, rx_ar_id;
  logic [31:0] rx_aw_addr, rx_ar_addr;
  logic [7:0] rx_aw_len, rx_ar_len;
  logic [2:0] rx_aw_size, rx_ar_size;
  logic [1:0] rx_aw_burst, rx_ar_burst;
  logic [127:0] rx_w_data;
  logic [15:0] rx_w_strb;
  logic aw_credit_rtn, w_credit_rtn, ar_credit_rtn;
  logic [3:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [127:0] m_axi_wdata, m_axi_rdata;
  logic [15:0] m_axi_wstrb;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic tx_b_valid, tx_b_ready, tx_r_valid, tx_r_ready, tx_r_last;
  logic [3:0] tx_b_id, tx_r_id;
  logic [1:0] tx_b_resp, tx_r_resp;
  logic [127:0] tx_r_data;
  logic err_overflow, err_wlast;

  aib_axi_bridge_follower_req_engine dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .rx_aw_valid(rx_aw_valid), .rx_aw_id(rx_aw_id), .rx_aw_addr(rx_aw_addr),
    .rx_aw_len(rx_aw_len), .rx_aw_size(rx_aw_size), .rx_aw_burst(rx_aw_burst),
    .rx_w_valid(rx_w_valid), .rx_w_data(rx_w_data), .rx_w_strb(rx_w_strb), .rx_w_last(rx_w_last),
    .rx_ar_valid(rx_ar_valid), .rx_ar_id(rx_ar_id), .rx_ar_addr(rx_ar_addr),
    .rx_ar_len(rx_ar_len), .rx_ar_size(rx_ar_size), .rx_ar_burst(rx_ar_burst),
    .aw_credit_rtn(aw_credit_rtn), .w_credit_rtn(w_credit_rtn), .ar_credit_rtn(ar_credit_rtn),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .tx_b_valid(tx_b_valid), .tx_b_ready(tx_b_ready), .tx_b_id(tx_b_id), .tx_b_resp(tx_b_resp),
    .tx_r_valid(tx_r_valid), .tx_r_ready(tx_r_ready), .tx_r_id(tx_r_id), .tx_r_data(tx_r_data),
    .tx_r_resp(tx_r_resp), .tx_r_last(tx_r_last),
    .err_overflow(err_overflow), .err_wlast(err_wlast));

  always #5 clk_wr = ~clk_wr;

  // ---------------- passive monitor (mid-cycle sampling) ----------------
  int aw_hs = 0, aw_cr = 0, w_cr = 0, ar_cr = 0;
  logic [31:0] aw_addr_log[$], w_data_log[$], ar_addr_log[$], r_data_log[$];
  logic w_last_log[$], r_last_log[$];

  always @(negedge clk_wr) begin
    if (m_axi_awvalid && m_axi_awready) begin
      aw_hs++;
      aw_addr_log.push_back(m_axi_awaddr);
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_data_log.push_back(m_axi_wdata[31:0]);
      w_last_log.push_back(m_axi_wlast);
    end
    if (m_axi_arvalid && m_axi_arready) ar_addr_log.push_back(m_axi_araddr);
    if (tx_r_valid && tx_r_ready) begin
      r_data_log.push_back(tx_r_data[31:0]);
      r_last_log.push_back(tx_r_last);
    end
    if (aw_credit_rtn) aw_cr++;
    if (w_credit_rtn)  w_cr++;
    if (ar_credit_rtn) ar_cr++;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic push_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    rx_aw_valid = 1'b1; rx_aw_id = id; rx_aw_addr = addr; rx_aw_len = len;
    rx_aw_size = 3'd4; rx_aw_burst = 2'd1;
    step();
    rx_aw_valid = 1'b0;
  endtask

  task automatic push_w(input logic [31:0] data, input logic last);
    rx_w_valid = 1'b1; rx_w_data = {96'h0, data}; rx_w_strb = 16'hFFFF; rx_w_last = last;
    step();
    rx_w_valid = 1'b0;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr);
    rx_ar_valid = 1'b1; rx_ar_id = id; rx_ar_addr = addr; rx_ar_len = 8'd0;
    rx_ar_size = 3'd4; rx_ar_burst = 2'd1;
    step();
    rx_ar_valid = 1'b0;
  endtask

  typedef struct {
    logic       bvalid;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       txready;
    logic       exp_bready;
    logic       exp_v;
    logic [3:0] exp_id;
    logic [1:0] exp_resp;
  } b_vec_t;

  b_vec_t bvec[7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, wbase, abase, rbase, c0, c1, c2, k;
    logic hs;

    // B path vectors: inputs for one cycle, expected bready in that cycle,
    // expected output register contents after the edge.
    bvec[0] = '{1'b1, 4'd5, 2'd0, 1'b0, 1'b1, 1'b1, 4'd5, 2'd0};
    bvec[1] = '{1'b1, 4'd6, 2'd1, 1'b0, 1'b0, 1'b1, 4'd5, 2'd0};
    bvec[2] = '{1'b1, 4'd6, 2'd1, 1'b1, 1'b1, 1'b1, 4'd6, 2'd1};
    bvec[3] = '{1'b0, 4'd0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd6, 2'd1};
    bvec[4] = '{1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd6, 2'd1};
    bvec[5] = '{1'b1, 4'd9, 2'd2, 1'b1, 1'b1, 1'b1, 4'd9, 2'd2};
    bvec[6] = '{1'b0, 4'd0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd9, 2'd2};

    rst_wr = 1'b1;
    rx_aw_valid = 0; rx_aw_id = 0; rx_aw_addr = 0; rx_aw_len = 0; rx_aw_size = 0; rx_aw_burst = 0;
    rx_w_valid = 0; rx_w_data = 0; rx_w_strb = 0; rx_w_last = 0;
    rx_ar_valid = 0; rx_ar_id = 0; rx_ar_addr = 0; rx_ar_len = 0; rx_ar_size = 0; rx_ar_burst = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bid = 0; m_axi_bresp = 0;
    m_axi_rvalid = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
    tx_b_ready = 0; tx_r_ready = 0;

    // ---------------- reset state ----------------
    repeat (3) step();
    check("rst_bready", m_axi_bready, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, tx_b_valid, tx_r_valid}, 0);
    check("rst_credits", {aw_credit_rtn, w_credit_rtn, ar_credit_rtn}, 0);
    check("rst_errs", {err_overflow, err_wlast}, 0);
    rst_wr = 1'b0;
    step();

    // ---------------- B response table ----------------
    for (int i = 0; i < 7; i++) begin
      m_axi_bvalid = bvec[i].bvalid; m_axi_bid = bvec[i].bid;
      m_axi_bresp = bvec[i].bresp; tx_b_ready = bvec[i].txready;
      #1;
      check($sformatf("bvec%0d_bready", i), m_axi_bready, bvec[i].exp_bready);
      step();
      check($sformatf("bvec%0d_txbvalid", i), tx_b_valid, bvec[i].exp_v);
      if (bvec[i].exp_v)
        check($sformatf("bvec%0d_txbid_resp", i), {tx_b_id, tx_b_resp}, {bvec[i].exp_id, bvec[i].exp_resp});
    end
    m_axi_bvalid = 0; tx_b_ready = 0;

    // ---------------- 1: single write burst ----------------
    m_axi_awready = 1; m_axi_wready = 1;
    base = aw_hs; wbase = w_data_log.size(); c0 = aw_cr; c1 = w_cr;
    push_aw(4'd3, 32'h1000, 8'd3);
    for (int i = 0; i < 4; i++) push_w(32'h10 + i, i == 3);
    repeat (12) step();
    check("t1_aw_hs", aw_hs - base, 1);
    check("t1_aw_addr", aw_addr_log[aw_addr_log.size()-1], 32'h1000);
    check("t1_w_beats", w_data_log.size() - wbase, 4);
    for (int i = 0; i < 4; i++) begin
      if (wbase + i < w_data_log.size()) begin
        check($sformatf("t1_wdata%0d", i), w_data_log[wbase+i], 32'h10 + i);
        check($sformatf("t1_wlast%0d", i), w_last_log[wbase+i], i == 3);
      end
    end
    check("t1_aw_credits", aw_cr - c0, 1);
    check("t1_w_credits", w_cr - c1, 4);
    m_axi_bvalid = 1; m_axi_bid = 4'd3; m_axi_bresp = 2'd0;
    step();
    m_axi_bvalid = 0;
    check("t1_b_ret", {tx_b_valid, tx_b_id, tx_b_resp}, {1'b1, 4'd3, 2'd0});
    tx_b_ready = 1;
    step();
    check("t1_b_drained", tx_b_valid, 0);

    // ---------------- 2: AR FIFO overflow ----------------
    m_axi_arready = 0;
    abase = ar_addr_log.size(); c2 = ar_cr;
    for (int i = 0; i < 8; i++) push_ar(i[3:0], 32'h2000 + 32'(i) * 32'h10);
    check("t2_no_ovf_at_8", err_overflow, 0);
    push_ar(4'hF, 32'hDEAD);
    check("t2_ovf_at_9", err_overflow, 1);
    check("t2_head", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h2000});
    m_axi_arready = 1;
    repeat (12) step();
    check("t2_ar_count", ar_addr_log.size() - abase, 8);
    for (int i = 0; i < 8; i++)
      if (abase + i < ar_addr_log.size())
        check($sformatf("t2_ar_order%0d", i), ar_addr_log[abase+i], 32'h2000 + 32'(i) * 32'h10);
    check("t2_ar_credits", ar_cr - c2, 8);

    // ---------------- 3: early W last flag ----------------
    wbase = w_data_log.size();
    check("t3_wlast_err_pre", err_wlast, 0);
    push_aw(4'd4, 32'h1100, 8'd3);
    for (int i = 0; i < 4; i++) push_w(32'h20 + i, i == 1);
    repeat (10) step();
    check("t3_err_wlast", err_wlast, 1);
    check("t3_w_beats", w_data_log.size() - wbase, 4);
    for (int i = 0; i < 4; i++)
      if (wbase + i < w_last_log.size())
        check($sformatf("t3_wlast%0d", i), w_last_log[wbase+i], i == 3);

    // ---------------- 4: R path stall ----------------
    rbase = r_data_log.size();
    k = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      m_axi_rvalid = (k < 4); m_axi_rid = 4'd2;
      m_axi_rdata = {96'h0, 32'hA0 + 32'(k)}; m_axi_rlast = (k == 3);
      tx_r_ready = !(cyc >= 2 && cyc < 7);
      #1;
      if (!tx_r_ready && tx_r_valid) check("t4_rready_held", m_axi_rready, 0);
      hs = m_axi_rvalid && m_axi_rready;
      step();
      if (hs) k++;
    end
    m_axi_rvalid = 0;
    check("t4_r_beats", r_data_log.size() - rbase, 4);
    for (int i = 0; i < 4; i++)
      if (rbase + i < r_data_log.size()) begin
        check($sformatf("t4_rdata%0d", i), r_data_log[rbase+i], 32'hA0 + i);
        check($sformatf("t4_rlast%0d", i), r_last_log[rbase+i], i == 3);
      end

    // ---------------- 5: reset mid-burst ----------------
    m_axi_wready = 0; m_axi_awready = 1;
    wbase = w_data_log.size();
    push_aw(4'd5, 32'h1200, 8'd3);
    for (int i = 0; i < 4; i++) push_w(32'h30 + i, i == 3);
    repeat (3) step();
    m_axi_wready = 1;
    repeat (2) step();
    m_axi_wready = 0;
    check("t5_two_beats", w_data_log.size() - wbase, 2);
    rst_wr = 1;
    step();
    check("t5_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, tx_b_valid, tx_r_valid}, 0);
    check("t5_credits", {aw_credit_rtn, w_credit_rtn, ar_credit_rtn}, 0);
    check("t5_errs", {err_overflow, err_wlast}, 0);
    check("t5_readies", {m_axi_bready, m_axi_rready}, 0);
    rst_wr = 0;
    base = aw_hs; wbase = w_data_log.size(); c0 = aw_cr; c1 = w_cr;
    m_axi_wready = 1;
    repeat (6) step();
    check("t5_flushed_hs", (aw_hs - base) + (w_data_log.size() - wbase), 0);
    check("t5_flushed_credits", (aw_cr - c0) + (w_cr - c1), 0);

    // ---------------- 6: push+pop on full W FIFO ----------------
    m_axi_wready = 0;
    wbase = w_data_log.size(); c1 = w_cr;
    push_aw(4'd7, 32'h3000, 8'd19);
    repeat (3) step();
    for (int i = 0; i < 16; i++) push_w(32'h100 + i, 1'b0);
    check("t6_full_no_ovf", err_overflow, 0);
    rx_w_valid = 1; rx_w_data = {96'h0, 32'h110}; rx_w_last = 0; m_axi_wready = 1;
    step();
    rx_w_valid = 0; m_axi_wready = 0;
    check("t6_pushpop_no_ovf", err_overflow, 0);
    m_axi_wready = 1;
    for (int i = 0; i < 40; i++) begin
      if (!m_axi_wvalid) break;
      step();
    end
    check("t6_occupancy16", w_data_log.size() - wbase, 17);
    for (int i = 0; i < 3; i++) push_w(32'h111 + i, i == 2);
    repeat (5) step();
    check("t6_total_beats", w_data_log.size() - wbase, 20);
    for (int i = 0; i < 20; i++)
      if (wbase + i < w_data_log.size()) begin
        check($sformatf("t6_order%0d", i), w_data_log[wbase+i], 32'h100 + i);
        check($sformatf("t6_wlast%0d", i), w_last_log[wbase+i], i == 19);
      end
    check("t6_errs", {err_overflow, err_wlast}, 0);
    check("t6_w_credits", w_cr - c1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
